booth_mult_issue_ctrl: RTL and testbench
========================================

// Module: booth_mult_issue_ctrl
// PURPOSE
//  Upstream issue stage for the Booth multiplier. Accepts operand pairs on a valid/ready stream
//  and buffers them in a small FIFO. Issues one START pulse per pair, waits for Done, and registers
//  RESULT onto a valid/ready output stream. A watchdog guards against a multiplier that never
//  asserts Done.
// PARAMETERS
//  DATAWIDTH   8   operand width; result is 2*DATAWIDTH
//  FIFO_DEPTH  2   operand FIFO entries; power of two, >=2
//  TIMEOUT     64  max WAIT cycles before error completion; >=DATAWIDTH+4
// PORTS
//  CLK         in   1      clock, rising edge
//  RST         in   1      synchronous, active-high reset
//  IN_VALID    in   1      operand pair valid
//  IN_READY    out  1      FIFO can accept (= !full)
//  IN_A        in   DW     multiplicand
//  IN_B        in   DW     multiplier
//  OUT_VALID   out  1      result valid
//  OUT_READY   in   1      consumer accepts result
//  OUT_RESULT  out  2*DW   product (0 on timeout)
//  OUT_ERR     out  1      qualifies OUT_VALID: 1 = timed out, RESULT invalid
//  MUL_START   out  1      one-cycle start pulse to multiplier
//  MUL_A       out  DW     operand A to multiplier, held ISSUE..WAIT
//  MUL_B       out  DW     operand B to multiplier, held ISSUE..WAIT
//  MUL_RESULT  in   2*DW   multiplier product
//  MUL_DONE    in   1      multiplier completion, sampled in WAIT only
// BEHAVIOUR
//  Reset: all registers cleared; FIFO emptied; state IDLE.
//  - OUT_VALID, OUT_ERR, OUT_RESULT, MUL_START, MUL_A, MUL_B = 0.
//  - IN_READY=0 while RST=1, 1 on the first cycle after.
//  - Reset mid-operation discards the FIFO contents and any in-flight pair.
//  - The multiplier must be reset in the same cycle (top ties RSTn = ~RST).
//  Input handshake: push when IN_VALID&&IN_READY. IN_READY is driven from the registered count.
//  Push and pop in the same cycle leave count unchanged. A push while full cannot occur.
//  Pointers wrap modulo FIFO_DEPTH.
//  FSM (registered):
//  - IDLE:  if FIFO non-empty, load MUL_A/MUL_B from head, then go to ISSUE.
//  - ISSUE: MUL_START=1 for exactly this cycle. Clear watchdog, then go to WAIT.
//  - WAIT:  watchdog increments each cycle.
//    - MUL_DONE=1: OUT_RESULT<=MUL_RESULT, OUT_ERR<=0, pop FIFO, go to HOLD.
//    - Otherwise, if watchdog==TIMEOUT-1: OUT_RESULT<=0, OUT_ERR<=1, pop, go to HOLD.
//    - If Done and timeout coincide, Done wins.
//  - HOLD:  OUT_VALID=1, with OUT_RESULT/OUT_ERR stable.
//    - On OUT_READY with FIFO non-empty: load the next head and go directly to ISSUE.
//    - On OUT_READY with FIFO empty: go to IDLE.
//  MUL_DONE outside WAIT is ignored. MUL_START never asserts outside ISSUE.
//  Latency: push at cycle t into an empty idle block gives MUL_START at t+2. MUL_DONE at cycle d
//  gives OUT_VALID at d+1.
//  Arithmetic: none in this block; product width 2*DATAWIDTH passed through unmodified.
// STRUCTURE
//  Shared package booth_pkg: FSM state encoding (IDLE/ISSUE/WAIT/HOLD), default DATAWIDTH,
//  and a clog2 helper for pointer and watchdog widths.
//  One sub-module: booth_operand_fifo.
//  - Stores {A,B} at 2*DATAWIDTH per entry.
//  - Ports: push, pop, full, empty, head data.
//  - Synchronous reset.
//  FSM, watchdog and output registers live in this module.
// TESTING
//  1. Single pair A=2,B=4, OUT_READY=1 -> one MUL_START pulse; OUT_VALID with RESULT=8, ERR=0.
//  2. Back-to-back (3,5),(4,6),(10,19) streamed:
//     - IN_READY drops when FIFO is full.
//     - RESULT order is 15, 24, 190.
//     - Exactly 3 START pulses.
//  3. OUT_READY=0 for 20 cycles on (32,45):
//     - OUT_VALID and RESULT=1440 held stable.
//     - No new START until accepted.
//     - Next pair (23,45) then yields 1035.
//  4. Stub multiplier never asserts Done:
//     - After TIMEOUT cycles in WAIT, OUT_VALID=1, ERR=1, RESULT=0.
//     - Next pair (32,12) then yields 384, ERR=0.
//  5. RST asserted one cycle while in WAIT with 2 entries queued:
//     - All outputs 0, FIFO empty.
//     - The late MUL_DONE is ignored.
//     - Fresh pair (32,15) yields 480.
//  6. MUL_DONE injected during IDLE/HOLD -> no OUT_VALID change, no FIFO pop.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier issue path: FSM encoding,
// default operand width and a ceiling-log2 helper for counter widths.
package booth_pkg;

   localparam int DEFAULT_DATAWIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int bits;
      int span;
      bits = 32'sd0;
      span = 32'sd1;
      while (span < value) begin
         span = span * 32'sd2;
         bits = bits + 32'sd1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/booth_operand_fifo.sv
// Small operand FIFO holding {A,B} pairs for the issue controller.
// Head data is always visible; pop only advances the read pointer.
module booth_operand_fifo
   import booth_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Out-of-range requests are dropped so the count can never wrap.
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign full  = (count_r == (PW+1)'(DEPTH));
   assign empty = (count_r == '0);

endmodule

// File: rtl/booth_mult_issue_ctrl.sv
// Issue stage for the Booth multiplier: buffers operand pairs, issues one start
// per pair, waits for done under a watchdog and presents the result on a stream.
module booth_mult_issue_ctrl
   import booth_pkg::*;
#(
   parameter int DATAWIDTH  = DEFAULT_DATAWIDTH,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATAWIDTH-1:0]   in_a,
   input  logic [DATAWIDTH-1:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*DATAWIDTH-1:0] out_result,
   output logic                   out_err,
   output logic                   mul_start,
   output logic [DATAWIDTH-1:0]   mul_a,
   output logic [DATAWIDTH-1:0]   mul_b,
   input  logic [2*DATAWIDTH-1:0] mul_result,
   input  logic                   mul_done
);

   localparam int                WW      = clog2(TIMEOUT);
   localparam logic [WW-1:0]     WD_LAST = WW'(TIMEOUT - 1);

   state_t                 state_r;
   logic [WW-1:0]          wd_r;
   logic                   rdy_en_r;
   logic                   out_valid_r;
   logic                   out_err_r;
   logic [2*DATAWIDTH-1:0] out_result_r;
   logic                   mul_start_r;
   logic [DATAWIDTH-1:0]   mul_a_r;
   logic [DATAWIDTH-1:0]   mul_b_r;

   logic [2*DATAWIDTH-1:0] head_s;
   logic                   full_s;
   logic                   empty_s;
   logic                   push_s;
   logic                   pop_s;

   booth_operand_fifo #(
      .WIDTH (2*DATAWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({in_a, in_b}),
      .head  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // rdy_en_r keeps the input closed during reset and opens it on the first cycle after.
   assign in_ready = rdy_en_r & ~full_s;
   assign push_s   = in_valid & in_ready;

   // The entry leaves the FIFO only when its WAIT phase completes (done or watchdog).
   always_comb begin
      pop_s = 1'b0;
      if (state_r == ST_WAIT) begin
         pop_s = mul_done | (wd_r == WD_LAST);
      end else begin
         pop_s = 1'b0;
      end
   end

   // Issue FSM, watchdog and all output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         wd_r         <= '0;
         rdy_en_r     <= 1'b0;
         out_valid_r  <= 1'b0;
         out_err_r    <= 1'b0;
         out_result_r <= '0;
         mul_start_r  <= 1'b0;
         mul_a_r      <= '0;
         mul_b_r      <= '0;
      end else begin
         rdy_en_r    <= 1'b1;
         mul_start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!empty_s) begin
                  mul_a_r     <= head_s[2*DATAWIDTH-1:DATAWIDTH];
                  mul_b_r     <= head_s[DATAWIDTH-1:0];
                  mul_start_r <= 1'b1;
                  state_r     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wd_r    <= '0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               wd_r <= wd_r + WW'(1);
               // Done has priority over a coincident watchdog expiry.
               if (mul_done) begin
                  out_result_r <= mul_result;
                  out_err_r    <= 1'b0;
                  out_valid_r  <= 1'b1;
                  state_r      <= ST_HOLD;
               end else if (wd_r == WD_LAST) begin
                  out_result_r <= '0;
                  out_err_r    <= 1'b1;
                  out_valid_r  <= 1'b1;
                  state_r      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (!empty_s) begin
                     mul_a_r     <= head_s[2*DATAWIDTH-1:DATAWIDTH];
                     mul_b_r     <= head_s[DATAWIDTH-1:0];
                     mul_start_r <= 1'b1;
                     state_r     <= ST_ISSUE;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid  = out_valid_r;
   assign out_err    = out_err_r;
   assign out_result = out_result_r;
   assign mul_start  = mul_start_r;
   assign mul_a      = mul_a_r;
   assign mul_b      = mul_b_r;

endmodule

// File: tb/tb_booth_mult_issue_ctrl.sv
// Bench for booth_mult_issue_ctrl: acts as the multiplier, models the pair
// stream with queues and compares every completed result against a*b or timeout.
module tb_booth_mult_issue_ctrl;

   localparam int DW = 8;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst, in_valid, in_ready, out_valid, out_ready, out_err;
   logic            mul_start, mul_done;
   logic [DW-1:0]   in_a, in_b, mul_a, mul_b;
   logic [2*DW-1:0] out_result, mul_result;

   always #5 clk = ~clk;

   booth_mult_issue_ctrl #(.DATAWIDTH(DW), .FIFO_DEPTH(2), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_err(out_err), .mul_start(mul_start),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_done(mul_done)
   );

   typedef struct {logic [DW-1:0] a; logic [DW-1:0] b; bit to;} pair_t;
   typedef struct {logic [DW-1:0] a; logic [DW-1:0] b; int lat; int exp;} vec_t;

   pair_t   pend[$];
   pair_t   issued[$];
   int      res_log[$];
   vec_t    tbl[5];

   int      n_vec = 0, n_err = 0, cyc = 0;
   int      cnt = 0, lat = 3, starts = 0, start_cyc = 0, push_cyc = 0;
   bit      no_done = 1'b0, rand_mode = 1'b0, pushed = 1'b0, saw_full = 1'b0;
   logic [2*DW-1:0] prod;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // One clock: record handshakes seen before the edge, then play the multiplier after it.
   task automatic step();
      pushed = 1'b0;
      if (!rst && in_valid && !in_ready) saw_full = 1'b1;
      if (!rst && in_valid && in_ready) begin
         pend.push_back('{in_a, in_b, 1'b0});
         pushed   = 1'b1;
         push_cyc = cyc + 1;
      end
      if (!rst && out_valid && out_ready) begin
         if (issued.size() == 0) check("out_unexpected", out_valid, 0);
         else begin
            pair_t p = issued.pop_front();
            check("out_result", out_result, p.to ? 0 : p.a * p.b);
            check("out_err", out_err, p.to);
            res_log.push_back(out_result);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      mul_done   = 1'b0;
      mul_result = 16'($urandom);
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin
            mul_done   = 1'b1;
            mul_result = prod;
         end
      end
      if (mul_start) begin
         starts++;
         start_cyc = cyc;
         if (pend.size() == 0) check("start_unexpected", mul_start, 0);
         else begin
            pair_t p = pend.pop_front();
            check("mul_a", mul_a, p.a);
            check("mul_b", mul_b, p.b);
            if (rand_mode) begin
               lat     = $urandom_range(1, 12);
               no_done = ($urandom_range(0, 15) == 0);
            end
            p.to = no_done;
            issued.push_back(p);
            prod = p.a * p.b;
            cnt  = no_done ? 0 : lat;
         end
      end
   endtask

   task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int k = 0;
      in_valid = 1'b1; in_a = a; in_b = b;
      do begin
         step();
         k++;
      end while (!pushed && k < 200);
      in_valid = 1'b0;
      if (!pushed) check("push_timeout", pushed, 1);
   endtask

   task automatic wait_start(input int s0);
      int k = 0;
      while (starts == s0 && k < 20) begin step(); k++; end
      if (starts == s0) check("start_timeout", starts - s0, 1);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!out_valid && k < budget) begin step(); k++; end
      if (!out_valid) check("out_valid_timeout", out_valid, 1);
   endtask

   task automatic drain(input int budget);
      int k = 0;
      in_valid = 1'b0; out_ready = 1'b1;
      while ((pend.size() != 0 || issued.size() != 0 || out_valid) && k < budget) begin
         step(); k++;
      end
      if (k >= budget) check("drain_timeout", pend.size() + issued.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0;
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_err", out_err, 0);
      check("rst_out_result", out_result, 0);
      check("rst_mul_start", mul_start, 0);
      check("rst_mul_ab", {mul_a, mul_b}, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      pend.delete(); issued.delete();
      step();
      check("post_rst_in_ready", in_ready, 1);
   endtask

   initial begin
      int s0, s1;
      bit stable;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      mul_done = 1'b0; mul_result = '0;
      step();
      do_reset();

      // Single pairs into an idle block: latencies and products.
      tbl[0] = '{8'd2,   8'd4,   1,  8};
      tbl[1] = '{8'd255, 8'd255, 3,  65025};
      tbl[2] = '{8'd0,   8'd77,  2,  0};
      tbl[3] = '{8'd128, 8'd2,   10, 256};
      tbl[4] = '{8'd1,   8'd1,   5,  1};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lat = tbl[i].lat;
         s0  = starts;
         push_pair(tbl[i].a, tbl[i].b);
         wait_start(s0);
         check("start_latency", start_cyc - push_cyc, 1);
         wait_valid(100);
         check("done_latency", cyc - start_cyc, tbl[i].lat + 1);
         check("tbl_result", out_result, tbl[i].exp);
         check("tbl_err", out_err, 0);
         step();
         check("tbl_start_count", starts - s0, 1);
         check("tbl_valid_drop", out_valid, 0);
      end

      // Back-to-back stream fills the FIFO.
      lat = 4; s0 = starts; saw_full = 1'b0; res_log.delete();
      push_pair(8'd3, 8'd5);
      push_pair(8'd4, 8'd6);
      push_pair(8'd10, 8'd19);
      drain(300);
      check("b2b_full_seen", saw_full, 1);
      check("b2b_starts", starts - s0, 3);
      check("b2b_r0", res_log.size() > 0 ? res_log[0] : -1, 15);
      check("b2b_r1", res_log.size() > 1 ? res_log[1] : -1, 24);
      check("b2b_r2", res_log.size() > 2 ? res_log[2] : -1, 190);

      // Back-pressure: result held, next pair waits for acceptance.
      out_ready = 1'b0; lat = 3; res_log.delete();
      push_pair(8'd32, 8'd45);
      wait_valid(50);
      push_pair(8'd23, 8'd45);
      s1 = starts; stable = 1'b1;
      repeat (20) begin
         step();
         if (!out_valid || out_result !== 16'd1440 || out_err) stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      check("hold_no_start", starts - s1, 0);
      drain(200);
      check("bp_r0", res_log.size() > 0 ? res_log[0] : -1, 1440);
      check("bp_r1", res_log.size() > 1 ? res_log[1] : -1, 1035);

      // Watchdog: multiplier never completes.
      no_done = 1'b1; s0 = starts;
      push_pair(8'd7, 8'd9);
      wait_start(s0);
      wait_valid(200);
      check("timeout_latency", cyc - start_cyc, TO + 1);
      check("timeout_err", out_err, 1);
      check("timeout_result", out_result, 0);
      step();
      no_done = 1'b0; lat = 2; res_log.delete();
      push_pair(8'd32, 8'd12);
      drain(200);
      check("after_to_r0", res_log.size() > 0 ? res_log[0] : -1, 384);

      // Reset while waiting with two entries queued; the late done must be ignored.
      lat = 8; s0 = starts;
      push_pair(8'd11, 8'd13);
      push_pair(8'd17, 8'd19);
      wait_start(s0);
      step(); step();
      do_reset();
      s1 = starts; stable = 1'b1;
      repeat (12) begin
         step();
         if (out_valid) stable = 1'b0;
      end
      check("rst_quiet", stable, 1);
      check("rst_fifo_empty", starts - s1, 0);
      lat = 3; res_log.delete();
      push_pair(8'd32, 8'd15);
      drain(200);
      check("after_rst_r0", res_log.size() > 0 ? res_log[0] : -1, 480);

      // Stray done in IDLE and in HOLD.
      mul_done = 1'b1; mul_result = 16'h1234;
      step(); step();
      check("idle_done_ignored", out_valid, 0);
      out_ready = 1'b0; lat = 2; res_log.delete();
      push_pair(8'd5, 8'd7);
      wait_valid(50);
      push_pair(8'd6, 8'd8);
      mul_done = 1'b1; mul_result = 16'hbeef;
      step(); step();
      check("hold_done_valid", out_valid, 1);
      check("hold_done_result", out_result, 35);
      drain(200);
      check("hold_r1", res_log.size() > 1 ? res_log[1] : -1, 48);

      // Randomized traffic against the queue model.
      rand_mode = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_a      = DW'($urandom);
         in_b      = DW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rand_mode = 1'b0;
      drain(3000);
      no_done = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
